pc_redirect_ctrl: RTL and testbench
===================================

# pc_redirect_ctrl

Sequencer for the program counter and front-end pipeline registers of the 5-stage core. It consumes the EX-stage branch/jump/halt resolution (select, target, halt) and the load-use stall request from the hazard unit. It owns the PC register, squashes the IF/ID and ID/EX registers on a redirect, and parks the core in a halted state until resumed.

## Interface
- `PC_W`, 9, PC register width in bits (byte address)
- `RESET_PC`, 0, PC value loaded on reset
- `CNT_W`, 16, width of the performance counters
- `clk` in 1: core clock
- `reset` in 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `ex_valid` in 1: EX stage holds a real (non-bubble) instruction
- `pc_sel` in 1: EX-stage redirect request (branch taken or jump)
- `br_pc` in 32: EX-stage redirect target
- `halt` in 1: EX-stage halt instruction
- `stall` in 1: load-use stall request from the hazard unit
- `resume` in 1: single-cycle pulse that leaves HALTED
- `pc_q` out PC_W: current fetch PC (registered)
- `pc_en` out 1: PC advanced or loaded this cycle
- `ifid_stall` out 1: hold the IF/ID register
- `ifid_flush` out 1: clear the IF/ID register to a bubble
- `idex_flush` out 1: clear the ID/EX register to a bubble
- `halted` out 1: high in HALTED
- `misalign` out 1: sticky flag; a redirect target had `br_pc[1:0] != 0`
- `redirect_cnt` out CNT_W: count of accepted redirects
- `stall_cnt` out CNT_W: count of stall cycles

## Operation
- FSM states: RUN, REDIRECT, HALTED. Reset state is RUN.
- RUN, evaluated in this priority order:
  - **Halt:** `ex_valid && halt`. `pc_q` holds. `ifid_flush=1`, `idex_flush=1`. Next state HALTED.
  - **Redirect:** `ex_valid && pc_sel`. `pc_q <= {br_pc[PC_W-1:2], 2'b00}`. `ifid_flush=1`, `idex_flush=1`. `pc_en=1`. Set `misalign` if `br_pc[1:0] != 0`. Next state REDIRECT. A simultaneous `stall` is ignored.
  - **Stall:** `stall`. `pc_q` holds. `pc_en=0`, `ifid_stall=1`, `idex_flush=1`.
  - **Otherwise:** `pc_q <= pc_q + 4`, `pc_en=1`.
- REDIRECT lasts exactly one cycle, then returns to RUN.
  - `ex_valid`, `pc_sel` and `halt` are ignored, because EX holds a flushed bubble.
  - `stall` is honoured as in RUN; otherwise the PC increments.
- HALTED:
  - `pc_en=0`, `ifid_flush=1`, `idex_flush=1` every cycle. `pc_q` is frozen.
  - `resume` returns the FSM to RUN. `pc_q` is unchanged; fetch continues on the next cycle.
- Arithmetic:
  - The PC increment is modulo 2^PC_W; wrap from `2^PC_W-4` to 0 is legal and silent.
  - Target bits at position PC_W and above are discarded.
- `misalign` clears only on reset.

## Timing
- Reset values:
  - `pc_q=RESET_PC`, state RUN, `misalign=0`, counters 0.
  - `pc_en=1` (the next edge increments).
  - All flush/stall outputs are 0 while `reset` is high.
- Flush and stall outputs are combinational from the current state and inputs, valid in the same cycle as the request.
- Redirect latency: request seen at edge t-1..t; `pc_q == target` after edge t; the first target instruction is in IF/ID after edge t+1.
- Halt takes effect in one cycle: `halted=1` after the next edge.
- `resume` asserted in RUN or REDIRECT has no effect.
- Reset asserted mid-redirect or mid-halt returns to RUN at `RESET_PC` immediately (asynchronous assertion); deassertion is synchronous to `clk`.

## Configuration
- Macro: `PC_REDIRECT_CNT_EN`.
- Defined:
  - `redirect_cnt` increments on each accepted redirect.
  - `stall_cnt` increments on each cycle with `ifid_stall=1`.
  - Both saturate at 2^CNT_W-1 and reset to 0.
- Undefined: both counters are tied to 0 and no counter flops are built. The port list is identical in both builds.

## Structure
- Package `pc_ctrl_pkg`:
  - `typedef enum logic [1:0] {RUN, REDIRECT, HALTED} pc_state_t`
  - `localparam PC_STEP = 4`
- Sub-module `sat_counter` (parameter W; inputs `clk`, `reset`, `inc`; output `cnt`). Instantiated twice, only under `PC_REDIRECT_CNT_EN`.

## Test plan
- Reset, then 4 free cycles: `pc_q` steps 0, 4, 8, 12, 16; flush and stall outputs stay 0.
- At `pc_q=0x10`, one cycle with `ex_valid=1`, `pc_sel=1`, `br_pc=0x40`: `ifid_flush` and `idex_flush` are high that cycle, then `pc_q=0x40`. A `pc_sel` pulse in the following REDIRECT cycle is ignored and `pc_q=0x44`.
- Redirect and stall in the same cycle, `br_pc=0x80`: `pc_q=0x80`, `ifid_stall=0`, `redirect_cnt=1`, `stall_cnt=0`.
- `ex_valid=1`, `halt=1`, `pc_sel=1`, `br_pc=0x20` at `pc_q=0x0C`: `pc_q` stays 0x0C and `halted=1` for 10 cycles with flushes high; a `resume` pulse gives `pc_q=0x10` one cycle after RUN resumes.
- `br_pc=0x1F3` with `PC_W=9`: `pc_q=0x1F0` and `misalign=1`; `misalign` stays set across later redirects until reset. Increments from `0x1FC` wrap to 0.
- Assert `reset` while in HALTED: `pc_q=RESET_PC`, `halted=0`, counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared types and constants for the PC redirect controller
package pc_ctrl_pkg;

    typedef enum logic [1:0] {RUN, REDIRECT, HALTED} pc_state_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with asynchronous active-high reset
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - PC register and front-end flush/stall sequencer (optional counters: PC_REDIRECT_CNT_EN)
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             pc_sel,
    input  logic [31:0]      br_pc,
    input  logic             halt,
    input  logic             stall,
    input  logic             resume,
    output logic [PC_W-1:0]  pc_q,
    output logic             pc_en,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic             misalign,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    pc_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_target;
    logic            misalign_q, misalign_d;
    logic            unused_br_hi;

    assign pc_inc       = pc_q + PC_W'(PC_STEP);
    assign pc_target    = {br_pc[PC_W-1:2], 2'b00};
    assign unused_br_hi = &{1'b0, br_pc[31:PC_W]};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        pc_en      = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_valid && halt) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    state_d    = HALTED;
                end else if (ex_valid && pc_sel) begin
                    pc_d       = pc_target;
                    pc_en      = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    state_d    = REDIRECT;
                    if (br_pc[1:0] != 2'b00) misalign_d = 1'b1;
                end else if (stall) begin
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end else begin
                    pc_d  = pc_inc;
                    pc_en = 1'b1;
                end
            end
            // EX holds the bubble created by the redirect flush, so its requests are meaningless here
            REDIRECT: begin
                state_d = RUN;
                if (stall) begin
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end else begin
                    pc_d  = pc_inc;
                    pc_en = 1'b1;
                end
            end
            HALTED: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (resume) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (reset) begin
            pc_en      = 1'b1;
            ifid_stall = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign halted   = (state_q == HALTED);
    assign misalign = misalign_q;

`ifdef PC_REDIRECT_CNT_EN
    logic redirect_inc;

    assign redirect_inc = !reset && (state_q == RUN) && ex_valid && pc_sel && !halt;

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect_inc),
        .cnt   (redirect_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ifid_stall),
        .cnt   (stall_cnt)
    );
`else
    assign redirect_cnt = '0;
    assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

`ifdef PC_REDIRECT_CNT_EN
    localparam logic [15:0] CNT_ONE = 16'd1;
`else
    localparam logic [15:0] CNT_ONE = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        reset, ex_valid, pc_sel, halt, stall, resume;
    logic [31:0] br_pc;
    logic [8:0]  pc_q;
    logic        pc_en, ifid_stall, ifid_flush, idex_flush, halted, misalign;
    logic [15:0] redirect_cnt, stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.PC_W(9), .RESET_PC(9'h000), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .pc_sel       (pc_sel),
        .br_pc        (br_pc),
        .halt         (halt),
        .stall        (stall),
        .resume       (resume),
        .pc_q         (pc_q),
        .pc_en        (pc_en),
        .ifid_stall   (ifid_stall),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .halted       (halted),
        .misalign     (misalign),
        .redirect_cnt (redirect_cnt),
        .stall_cnt    (stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid = 1'b0; pc_sel = 1'b0; halt = 1'b0; stall = 1'b0; resume = 1'b0; br_pc = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] exp_pc;
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        stall = 1'b1;
        #1;
        n_checks++; if (pc_q !== 9'h000) begin n_fail++; $display("FAIL reset_pc: got %h exp 000", pc_q); end
        n_checks++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL reset_pc_en: got %b exp 1", pc_en); end
        n_checks++; if ({ifid_stall, ifid_flush, idex_flush} !== 3'b000) begin n_fail++; $display("FAIL reset_flush: got %b exp 000", {ifid_stall, ifid_flush, idex_flush}); end
        n_checks++; if ({halted, misalign} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b exp 00", {halted, misalign}); end
        n_checks++; if (redirect_cnt !== 16'd0 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", redirect_cnt, stall_cnt); end
        stall = 1'b0;
        reset = 1'b0;
        exp_pc = 9'h000;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (pc_q !== exp_pc) begin n_fail++; $display("FAIL free_pc[%0d]: got %h exp %h", i, pc_q, exp_pc); end
            n_checks++; if ({ifid_stall, ifid_flush, idex_flush} !== 3'b000) begin n_fail++; $display("FAIL free_flush[%0d]: got %b exp 000", i, {ifid_stall, ifid_flush, idex_flush}); end
            if (i < 4) tick();
            exp_pc = exp_pc + 9'd4;
        end
    endtask

    task automatic test_redirect();
        ex_valid = 1'b1; pc_sel = 1'b1; br_pc = 32'h40;
        #1;
        n_checks++; if ({ifid_flush, idex_flush, pc_en} !== 3'b111) begin n_fail++; $display("FAIL redir_flush: got %b exp 111", {ifid_flush, idex_flush, pc_en}); end
        tick();
        n_checks++; if (pc_q !== 9'h040) begin n_fail++; $display("FAIL redir_pc: got %h exp 040", pc_q); end
        br_pc = 32'h100;
        #1;
        n_checks++; if ({ifid_flush, idex_flush} !== 2'b00) begin n_fail++; $display("FAIL redir_ignore_flush: got %b exp 00", {ifid_flush, idex_flush}); end
        tick();
        clear_inputs();
        n_checks++; if (pc_q !== 9'h044) begin n_fail++; $display("FAIL redir_ignore_pc: got %h exp 044", pc_q); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL redir_misalign: got %b exp 0", misalign); end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        ex_valid = 1'b1; pc_sel = 1'b1; stall = 1'b1; br_pc = 32'h80;
        #1;
        n_checks++; if ({ifid_stall, ifid_flush} !== 2'b01) begin n_fail++; $display("FAIL rs_outputs: got %b exp 01", {ifid_stall, ifid_flush}); end
        tick();
        clear_inputs();
        n_checks++; if (pc_q !== 9'h080) begin n_fail++; $display("FAIL rs_pc: got %h exp 080", pc_q); end
        n_checks++; if (redirect_cnt !== CNT_ONE) begin n_fail++; $display("FAIL rs_redirect_cnt: got %0d exp %0d", redirect_cnt, CNT_ONE); end
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rs_stall_cnt: got %0d exp 0", stall_cnt); end
        stall = 1'b1;
        #1;
        n_checks++; if ({ifid_stall, idex_flush, pc_en} !== 3'b110) begin n_fail++; $display("FAIL stall_outputs: got %b exp 110", {ifid_stall, idex_flush, pc_en}); end
        tick();
        stall = 1'b0;
        n_checks++; if (pc_q !== 9'h080) begin n_fail++; $display("FAIL stall_hold: got %h exp 080", pc_q); end
        n_checks++; if (stall_cnt !== CNT_ONE) begin n_fail++; $display("FAIL stall_cnt: got %0d exp %0d", stall_cnt, CNT_ONE); end
        tick();
        n_checks++; if (pc_q !== 9'h084) begin n_fail++; $display("FAIL stall_release: got %h exp 084", pc_q); end
    endtask

    task automatic test_halt();
        do_reset();
        tick(); tick(); tick();
        n_checks++; if (pc_q !== 9'h00C) begin n_fail++; $display("FAIL halt_setup: got %h exp 00c", pc_q); end
        ex_valid = 1'b1; halt = 1'b1; pc_sel = 1'b1; br_pc = 32'h20;
        #1;
        n_checks++; if ({ifid_flush, idex_flush, pc_en} !== 3'b110) begin n_fail++; $display("FAIL halt_req: got %b exp 110", {ifid_flush, idex_flush, pc_en}); end
        tick();
        clear_inputs();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (halted !== 1'b1 || pc_q !== 9'h00C || {ifid_flush, idex_flush, pc_en} !== 3'b110) begin
                n_fail++;
                $display("FAIL halted[%0d]: got halted=%b pc=%h fl/en=%b exp 1 00c 110", i, halted, pc_q, {ifid_flush, idex_flush, pc_en});
            end
            tick();
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        n_checks++; if (halted !== 1'b0 || pc_q !== 9'h00C) begin n_fail++; $display("FAIL resume_state: got halted=%b pc=%h exp 0 00c", halted, pc_q); end
        tick();
        n_checks++; if (pc_q !== 9'h010) begin n_fail++; $display("FAIL resume_pc: got %h exp 010", pc_q); end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        n_checks++; if (pc_q !== 9'h014 || halted !== 1'b0) begin n_fail++; $display("FAIL resume_in_run: got pc=%h halted=%b exp 014 0", pc_q, halted); end
    endtask

    task automatic test_misalign_wrap();
        logic [8:0] exp_pc;
        do_reset();
        ex_valid = 1'b1; pc_sel = 1'b1; br_pc = 32'h1F3;
        tick();
        clear_inputs();
        n_checks++; if (pc_q !== 9'h1F0 || misalign !== 1'b1) begin n_fail++; $display("FAIL misalign_redir: got pc=%h mis=%b exp 1f0 1", pc_q, misalign); end
        exp_pc = 9'h1F0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_pc = exp_pc + 9'd4;
        end
        n_checks++; if (pc_q !== 9'h000 || exp_pc !== pc_q) begin n_fail++; $display("FAIL wrap: got %h exp 000", pc_q); end
        tick();
        ex_valid = 1'b1; pc_sel = 1'b1; br_pc = 32'h240;
        tick();
        clear_inputs();
        n_checks++; if (pc_q !== 9'h040 || misalign !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky: got pc=%h mis=%b exp 040 1", pc_q, misalign); end
    endtask

    task automatic test_reset_in_halt();
        do_reset();
        tick(); tick();
        ex_valid = 1'b1; halt = 1'b1;
        tick();
        clear_inputs();
        n_checks++; if (halted !== 1'b1 || pc_q !== 9'h008) begin n_fail++; $display("FAIL rih_setup: got halted=%b pc=%h exp 1 008", halted, pc_q); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (pc_q !== 9'h000 || halted !== 1'b0) begin n_fail++; $display("FAIL rih_async: got pc=%h halted=%b exp 000 0", pc_q, halted); end
        n_checks++; if (redirect_cnt !== 16'd0 || stall_cnt !== 16'd0 || misalign !== 1'b0) begin n_fail++; $display("FAIL rih_cnt: got %0d/%0d mis=%b exp 0/0 0", redirect_cnt, stall_cnt, misalign); end
        n_checks++; if ({ifid_flush, idex_flush, pc_en} !== 3'b001) begin n_fail++; $display("FAIL rih_outputs: got %b exp 001", {ifid_flush, idex_flush, pc_en}); end
        reset = 1'b0;
        tick();
        n_checks++; if (pc_q !== 9'h004) begin n_fail++; $display("FAIL rih_restart: got %h exp 004", pc_q); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_redirect();
        test_redirect_stall();
        test_halt();
        test_misalign_wrap();
        test_reset_in_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
